// File: rtl/uart_cmd_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_pkg
// Description : Shared types and constants for the UART command parser.
// Revision    : 1.0 - initial release
// ============================================================================
package uart_cmd_pkg;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        GET_CMD = 3'd1,
        GET_HI  = 3'd2,
        GET_LO  = 3'd3,
        GET_CHK = 3'd4
    } state_t;

    localparam logic [7:0] DEF_HDR_BYTE = 8'hAA;

    localparam logic [7:0] CMD_GO   = 8'h47;
    localparam logic [7:0] CMD_STOP = 8'h53;

endpackage
`default_nettype wire

// File: rtl/uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : uart_cmd_ctrl
// Description : Assembles 5-byte framed commands (hdr, cmd, hi, lo, chk) from
//               the UART receiver byte stream with inter-byte timeout.
// Revision    : 1.0 - initial release
// ============================================================================
module uart_cmd_ctrl
    import uart_cmd_pkg::*;
#(
    parameter logic [7:0] HDR_BYTE       = DEF_HDR_BYTE,
    parameter int         TIMEOUT_CYCLES = 1_000_000
) (
    input  logic        clk,
    input  logic        rst_n,
    input  logic [7:0]  rx_data,
    input  logic        rx_rdy,
    output logic        clr_rx_rdy,
    input  logic        clr_cmd_rdy,
    output logic        cmd_rdy,
    output logic [7:0]  cmd,
    output logic [15:0] data,
    output logic        cksum_err,
    output logic        timeout_err,
    output logic        ovr_err
);

    localparam int CNT_W = $clog2(TIMEOUT_CYCLES);
    // Terminal compare is one below the target so the counter lands on
    // TIMEOUT_CYCLES-1 on the same edge that aborts the packet.
    localparam logic [CNT_W-1:0] c_TMO_TERM = CNT_W'(TIMEOUT_CYCLES - 2);

    state_t             r_state;
    state_t             w_state_nxt;
    logic               r_clr_rx_rdy;
    logic [7:0]         r_cmd_sh;
    logic [7:0]         r_hi_sh;
    logic [7:0]         r_lo_sh;
    logic [CNT_W-1:0]   r_tmo_cnt;
    logic               r_cmd_rdy;
    logic [7:0]         r_cmd;
    logic [15:0]        r_data;
    logic               r_cksum_err;
    logic               r_timeout_err;
    logic               r_ovr_err;

    logic               w_accept;
    logic [7:0]         w_sum;
    logic               w_chk_byte;
    logic               w_good;
    logic               w_bad;
    logic               w_timeout;

    assign w_accept   = rx_rdy & ~r_clr_rx_rdy;
    assign w_sum      = r_cmd_sh + r_hi_sh + r_lo_sh + rx_data;
    assign w_chk_byte = w_accept && (r_state == GET_CHK);
    assign w_good     = w_chk_byte && (w_sum == 8'h00);
    assign w_bad      = w_chk_byte && (w_sum != 8'h00);
    assign w_timeout  = (r_state != IDLE) && !w_accept && (r_tmo_cnt == c_TMO_TERM);

    always_comb begin
        w_state_nxt = r_state;
        if (w_timeout) begin
            w_state_nxt = IDLE;
        end else if (w_accept) begin
            case (r_state)
                IDLE:    w_state_nxt = (rx_data == HDR_BYTE) ? GET_CMD : IDLE;
                GET_CMD: w_state_nxt = GET_HI;
                GET_HI:  w_state_nxt = GET_LO;
                GET_LO:  w_state_nxt = GET_CHK;
                GET_CHK: w_state_nxt = IDLE;
                default: w_state_nxt = IDLE;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    // Receiver handshake: hold the clear until the receiver drops rdy.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_clr_rx_rdy <= 1'b0;
        end else if (w_accept) begin
            r_clr_rx_rdy <= 1'b1;
        end else if (!rx_rdy) begin
            r_clr_rx_rdy <= 1'b0;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_sh <= 8'h00;
            r_hi_sh  <= 8'h00;
            r_lo_sh  <= 8'h00;
        end else if (w_accept) begin
            case (r_state)
                GET_CMD: r_cmd_sh <= rx_data;
                GET_HI:  r_hi_sh  <= rx_data;
                GET_LO:  r_lo_sh  <= rx_data;
                default: ;
            endcase
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_tmo_cnt <= '0;
        end else if ((r_state == IDLE) || w_accept) begin
            r_tmo_cnt <= '0;
        end else begin
            r_tmo_cnt <= r_tmo_cnt + CNT_W'(1);
        end
    end

    // Set beats clear so a command landing with an ack is never lost.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            r_cmd_rdy     <= 1'b0;
            r_cmd         <= 8'h00;
            r_data        <= 16'h0000;
            r_cksum_err   <= 1'b0;
            r_timeout_err <= 1'b0;
            r_ovr_err     <= 1'b0;
        end else begin
            r_cksum_err   <= w_bad;
            r_timeout_err <= w_timeout;
            r_ovr_err     <= w_good & r_cmd_rdy;
            if (w_good) begin
                r_cmd_rdy <= 1'b1;
                r_cmd     <= r_cmd_sh;
                r_data    <= {r_hi_sh, r_lo_sh};
            end else if (clr_cmd_rdy) begin
                r_cmd_rdy <= 1'b0;
            end
        end
    end

    assign clr_rx_rdy  = r_clr_rx_rdy;
    assign cmd_rdy     = r_cmd_rdy;
    assign cmd         = r_cmd;
    assign data        = r_data;
    assign cksum_err   = r_cksum_err;
    assign timeout_err = r_timeout_err;
    assign ovr_err     = r_ovr_err;

endmodule
`default_nettype wire

// File: tb/tb_uart_cmd_ctrl.sv
`default_nettype none
// ============================================================================
// Module      : tb_uart_cmd_ctrl
// Description : Directed self-checking bench for uart_cmd_ctrl.
// Revision    : 1.0 - initial release
// ============================================================================
module tb_uart_cmd_ctrl;

    localparam int TMO = 1000;

    logic        clk;
    logic        rst_n;
    logic [7:0]  rx_data;
    logic        rx_rdy;
    logic        clr_rx_rdy;
    logic        clr_cmd_rdy;
    logic        cmd_rdy;
    logic [7:0]  cmd;
    logic [15:0] data;
    logic        cksum_err;
    logic        timeout_err;
    logic        ovr_err;

    int n_cmp = 0;
    int n_err = 0;
    int clr_rises = 0;
    int n_cksum = 0;
    int n_tmo = 0;
    int n_ovr = 0;
    logic clr_prev = 1'b0;

    uart_cmd_ctrl #(
        .HDR_BYTE       (8'hAA),
        .TIMEOUT_CYCLES (TMO)
    ) u_dut (
        .clk         (clk),
        .rst_n       (rst_n),
        .rx_data     (rx_data),
        .rx_rdy      (rx_rdy),
        .clr_rx_rdy  (clr_rx_rdy),
        .clr_cmd_rdy (clr_cmd_rdy),
        .cmd_rdy     (cmd_rdy),
        .cmd         (cmd),
        .data        (data),
        .cksum_err   (cksum_err),
        .timeout_err (timeout_err),
        .ovr_err     (ovr_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Pulse/handshake activity counted at the falling edge.
    always @(negedge clk) begin
        if (clr_rx_rdy && !clr_prev) clr_rises++;
        clr_prev = clr_rx_rdy;
        if (cksum_err)   n_cksum++;
        if (timeout_err) n_tmo++;
        if (ovr_err)     n_ovr++;
    end

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    // Returns just after the accept edge; ack asserts clr_cmd_rdy in the accept cycle.
    task automatic send_byte(input logic [7:0] b, input logic ack);
        int guard;
        guard = 0;
        while (clr_rx_rdy && guard < 20) begin
            tick();
            guard++;
        end
        rx_data     = b;
        rx_rdy      = 1'b1;
        clr_cmd_rdy = ack;
        guard = 0;
        do begin
            tick();
            guard++;
        end while (!clr_rx_rdy && guard < 20);
        clr_cmd_rdy = 1'b0;
        check("rx_handshake", 32'(clr_rx_rdy), 32'd1);
        rx_rdy = 1'b0;
    endtask

    task automatic send_pkt(input logic [7:0] c, input logic [7:0] hi,
                            input logic [7:0] lo, input logic [7:0] ck, input logic ack);
        send_byte(8'hAA, 1'b0);
        send_byte(c, 1'b0);
        send_byte(hi, 1'b0);
        send_byte(lo, 1'b0);
        send_byte(ck, ack);
    endtask

    task automatic ack_cmd();
        clr_cmd_rdy = 1'b1;
        tick();
        clr_cmd_rdy = 1'b0;
    endtask

    initial begin
        int n;
        int base;
        rst_n       = 1'b0;
        rx_data     = 8'h00;
        rx_rdy      = 1'b0;
        clr_cmd_rdy = 1'b0;
        #23;
        check("rst_cmd_rdy", 32'(cmd_rdy), 32'd0);
        check("rst_cmd", 32'(cmd), 32'h00);
        check("rst_data", 32'(data), 32'h0000);
        check("rst_clr_rx", 32'(clr_rx_rdy), 32'd0);
        check("rst_errs", {29'd0, cksum_err, timeout_err, ovr_err}, 32'd0);
        rst_n = 1'b1;
        tick();
        tick();

        // Good packet: cmd_rdy visible right after the CHK accept edge.
        send_pkt(8'h47, 8'h01, 8'h02, 8'hB6, 1'b0);
        check("good_rdy", 32'(cmd_rdy), 32'd1);
        check("good_cmd", 32'(cmd), 32'h47);
        check("good_data", 32'(data), 32'h0102);
        tick();
        tick();
        check("good_rx_clrs", 32'(clr_rises), 32'd5);
        check("good_no_err", 32'(n_cksum + n_tmo + n_ovr), 32'd0);
        ack_cmd();
        check("ack_clears", 32'(cmd_rdy), 32'd0);
        check("ack_cmd_held", 32'(cmd), 32'h47);

        // Garbage ahead of a packet is consumed and dropped.
        send_byte(8'h00, 1'b0);
        send_byte(8'hFF, 1'b0);
        send_byte(8'h55, 1'b0);
        send_pkt(8'h53, 8'h00, 8'h00, 8'hAD, 1'b0);
        check("garb_rdy", 32'(cmd_rdy), 32'd1);
        check("garb_cmd", 32'(cmd), 32'h53);
        check("garb_data", 32'(data), 32'h0000);
        tick();
        tick();
        check("garb_rx_clrs", 32'(clr_rises), 32'd13);
        ack_cmd();

        // Bad checksum: one-cycle cksum_err, outputs untouched.
        send_pkt(8'h47, 8'h01, 8'h02, 8'hB7, 1'b0);
        check("bad_pulse", 32'(cksum_err), 32'd1);
        check("bad_rdy", 32'(cmd_rdy), 32'd0);
        check("bad_cmd_held", 32'(cmd), 32'h53);
        tick();
        check("bad_pulse_end", 32'(cksum_err), 32'd0);
        tick();
        check("bad_cnt", 32'(n_cksum), 32'd1);
        send_pkt(8'h47, 8'h01, 8'h02, 8'hB6, 1'b0);
        check("after_bad_rdy", 32'(cmd_rdy), 32'd1);
        check("after_bad_cmd", 32'(cmd), 32'h47);
        ack_cmd();

        // Timeout: pulse 999 cycles after the last accept edge.
        send_byte(8'hAA, 1'b0);
        send_byte(8'h47, 1'b0);
        n = 0;
        do begin
            tick();
            n++;
        end while (!timeout_err && n < 2 * TMO);
        check("tmo_latency", 32'(n), 32'(TMO - 1));
        tick();
        check("tmo_pulse_end", 32'(timeout_err), 32'd0);
        tick();
        check("tmo_cnt", 32'(n_tmo), 32'd1);
        check("tmo_rdy", 32'(cmd_rdy), 32'd0);
        send_pkt(8'h47, 8'h01, 8'h02, 8'hB6, 1'b0);
        check("after_tmo_rdy", 32'(cmd_rdy), 32'd1);
        check("after_tmo_data", 32'(data), 32'h0102);

        // Overwrite of an unacknowledged command.
        send_pkt(8'h53, 8'h12, 8'h34, 8'h67, 1'b0);
        check("ovr_pulse", 32'(ovr_err), 32'd1);
        check("ovr_cmd", 32'(cmd), 32'h53);
        check("ovr_data", 32'(data), 32'h1234);
        tick();
        check("ovr_pulse_end", 32'(ovr_err), 32'd0);

        // Ack coincident with set: set wins.
        send_pkt(8'h47, 8'hAB, 8'hCD, 8'h41, 1'b1);
        check("setwin_rdy", 32'(cmd_rdy), 32'd1);
        check("setwin_data", 32'(data), 32'hABCD);
        tick();
        check("setwin_rdy_hold", 32'(cmd_rdy), 32'd1);
        check("ovr_cnt", 32'(n_ovr), 32'd2);

        // Header value inside the payload is plain data.
        ack_cmd();
        send_pkt(8'h47, 8'hAA, 8'h00, 8'h0F, 1'b0);
        check("hdr_data_rdy", 32'(cmd_rdy), 32'd1);
        check("hdr_data", 32'(data), 32'hAA00);

        // Asynchronous reset in the middle of a packet.
        send_byte(8'hAA, 1'b0);
        send_byte(8'h53, 1'b0);
        #2;
        rst_n = 1'b0;
        #1;
        check("arst_rdy", 32'(cmd_rdy), 32'd0);
        check("arst_cmd", 32'(cmd), 32'h00);
        check("arst_data", 32'(data), 32'h0000);
        check("arst_clr_rx", 32'(clr_rx_rdy), 32'd0);
        tick();
        #2;
        rst_n = 1'b1;
        tick();
        base = n_ovr;
        send_pkt(8'h53, 8'h00, 8'h00, 8'hAD, 1'b0);
        check("post_rst_rdy", 32'(cmd_rdy), 32'd1);
        check("post_rst_cmd", 32'(cmd), 32'h53);
        check("post_rst_data", 32'(data), 32'h0000);
        tick();
        tick();
        check("post_rst_no_ovr", 32'(n_ovr - base), 32'd0);
        check("final_err_cnts", 32'(n_cksum * 16 + n_tmo), 32'h11);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/uart_cmd_ctrl.md
Name: uart_cmd_ctrl

Overview:
Sequences the UART receiver and assembles framed 5-byte command packets from its byte stream. It consumes each received byte through the receiver's rdy/clr_rdy handshake and validates header and checksum. Each good packet is presented to the Segway control logic as cmd/data with a ready flag. It sits between the UART receiver (instantiated alongside it in the parent) and the auth/steer logic. It also enforces an inter-byte timeout so a broken packet cannot wedge the parser.

Parameters:
HDR_BYTE, 8'hAA, packet start byte
TIMEOUT_CYCLES, 1_000_000, max clk cycles allowed between bytes of one packet (20 ms at 50 MHz); counter width = $clog2(TIMEOUT_CYCLES)

Ports:
clk  input  1  system clock, 50 MHz
rst_n  input  1  asynchronous active-low reset
rx_data  input  8  byte from UART receiver
rx_rdy  input  1  receiver byte-ready flag (level)
clr_rx_rdy  output  1  clear request to receiver (drives its clr_rdy)
clr_cmd_rdy  input  1  consumer acknowledges command
cmd_rdy  output  1  valid command held on cmd/data
cmd  output  8  command opcode
data  output  16  command payload, {hi,lo}
cksum_err  output  1  one-cycle pulse: checksum mismatch, packet dropped
timeout_err  output  1  one-cycle pulse: inter-byte timeout, packet dropped
ovr_err  output  1  one-cycle pulse: new packet overwrote an unacknowledged one

Behaviour:
- Reset (async, rst_n low): state IDLE; all outputs 0; cmd/data 0; shadow regs and timeout counter 0.
- Packet: HDR_BYTE, CMD, DATA_HI, DATA_LO, CHK. Valid when (CMD+DATA_HI+DATA_LO+CHK) mod 256 == 8'h00.
- Byte handshake: a byte is accepted on a cycle where rx_rdy=1 and clr_rx_rdy=0. clr_rx_rdy is registered: it goes high the cycle after acceptance and stays high until rx_rdy is sampled 0, then drops next cycle. Exactly one acceptance per received byte.
- FSM states: IDLE, GET_CMD, GET_HI, GET_LO, GET_CHK.
  - IDLE: accepted byte == HDR_BYTE -> GET_CMD. Any other byte is consumed and discarded; stay IDLE.
  - GET_CMD / GET_HI / GET_LO: accepted byte latched into the shadow cmd/hi/lo registers; advance to next state.
  - GET_CHK: on accepted byte, go to IDLE. Checksum good -> next cycle cmd, data and cmd_rdy=1 are updated from the shadow regs. Checksum bad -> pulse cksum_err; outputs unchanged.
- A header byte received mid-packet is treated as data; there is no resync except via checksum failure or timeout.
- Timeout: the counter is cleared on every accepted byte and in IDLE, and increments in every non-IDLE state. When it reaches TIMEOUT_CYCLES-1: go to IDLE, pulse timeout_err, outputs unchanged.
- cmd/data change only on a good packet. They are stable whenever cmd_rdy=1 unless overwritten.
- cmd_rdy: set on good packet, cleared by clr_cmd_rdy. If both occur in the same cycle, set wins. A good packet arriving while cmd_rdy=1 overwrites cmd/data and pulses ovr_err in the same cycle as the update.
- Latency: cmd_rdy rises exactly 1 clk after the cycle the CHK byte is accepted.
- Error pulses are exactly 1 cycle and mutually exclusive per packet.

Decomposition:
- Package uart_cmd_pkg holds:
  - typedef enum logic [2:0] for the parser state;
  - localparam HDR_BYTE default;
  - command opcodes CMD_GO=8'h47 ('G'), CMD_STOP=8'h53 ('S').
- No sub-module required. The timeout counter and the handshake flop stay inline.
- The UART receiver is instantiated by the parent, not inside this block.

Test Plan:
- Good packet AA 47 01 02 B6 -> one cycle after CHK accept: cmd_rdy=1, cmd=8'h47, data=16'h0102; no error pulses; exactly 5 clr_rx_rdy assertions.
- Garbage 00 FF 55 then AA 53 00 00 AD -> garbage bytes consumed and discarded; cmd=8'h53, data=16'h0000, cmd_rdy=1.
- Bad checksum AA 47 01 02 B7 -> single cksum_err pulse; cmd_rdy remains 0; FSM back in IDLE; following good packet accepted.
- AA 47 then silence for TIMEOUT_CYCLES (use parameter 1000 in bench) -> timeout_err pulse at cycle 999 after last accept; a subsequent full packet is decoded correctly.
- Two good packets without clr_cmd_rdy (second AA 53 12 34 67) -> ovr_err pulse; cmd=8'h53, data=16'h1234. Assert clr_cmd_rdy in the same cycle as a third packet's set -> cmd_rdy stays 1.
- Assert rst_n low during GET_HI -> all outputs 0 immediately; FSM IDLE; next packet decodes normally.
